// File: rtl/seq_pattern_gen_pkg.sv
// Shared constants and state encoding for the 1011 pattern generator.
// Also used by the matching detector bench.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 4'b1011;

    // States in which the stream carries meaningful bits.
    function automatic logic is_active(input state_t s);
        return (s == SEND) || (s == GAP);
    endfunction

endpackage

// File: rtl/seq_pattern_gen_piso.sv
// Parallel-in serial-out register, MSB presented first.
// Load wins over shift when both are requested.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    // Load a fresh pattern or advance one bit toward the MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: repeats PAT with optional zero gaps.
// Optional abort input enabled by SEQ_PATTERN_GEN_ABORT_EN.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int               PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT   = DEF_PAT,
    parameter int               CNT_W = 8,
    parameter int               GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             out_ready,
`ifdef SEQ_PATTERN_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] rep_left, rep_next;
    logic [GAP_W-1:0] gap_reg, gap_reg_next;
    logic [GAP_W-1:0] gap_idx, gap_idx_next;
    logic [IDX_W-1:0] bit_idx, bit_idx_next;
    logic             pload, pshift;
    logic             pat_msb;
    logic             abort_hit;
    logic             xfer;

`ifdef SEQ_PATTERN_GEN_ABORT_EN
    assign abort_hit = abort && is_active(state);
`else
    assign abort_hit = 1'b0;
`endif

    // An abort in the same cycle cancels the transfer.
    assign xfer = out_valid && out_ready && !abort_hit;

    seq_piso #(.W(PAT_W)) u_piso (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pload),
        .shift   (pshift),
        .din     (PAT),
        .msb     (pat_msb)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rep_left <= '0;
            gap_reg  <= '0;
            gap_idx  <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_next;
            rep_left <= rep_next;
            gap_reg  <= gap_reg_next;
            gap_idx  <= gap_idx_next;
            bit_idx  <= bit_idx_next;
        end
    end

    // Next-state, counter updates and shift-register control.
    always_comb begin
        state_next   = state;
        rep_next     = rep_left;
        gap_reg_next = gap_reg;
        gap_idx_next = gap_idx;
        bit_idx_next = bit_idx;
        pload        = 1'b0;
        pshift       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    rep_next     = repeat_cnt;
                    gap_reg_next = gap_len;
                    bit_idx_next = IDX_LAST;
                    pload        = 1'b1;
                    state_next   = (repeat_cnt != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    if (bit_idx == '0) begin
                        rep_next = rep_left - CNT_W'(1);
                        if (rep_left == CNT_W'(1)) begin
                            state_next = DONE;
                        end else if (gap_reg == '0) begin
                            pload        = 1'b1;
                            bit_idx_next = IDX_LAST;
                        end else begin
                            gap_idx_next = gap_reg;
                            state_next   = GAP;
                        end
                    end else begin
                        pshift       = 1'b1;
                        bit_idx_next = bit_idx - IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    if (gap_idx == GAP_W'(1)) begin
                        pload        = 1'b1;
                        bit_idx_next = IDX_LAST;
                        state_next   = SEND;
                    end else begin
                        gap_idx_next = gap_idx - GAP_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        out_valid = is_active(state);
        out_bit   = (state == SEND) && pat_msb;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen.
// Abort scenario included when SEQ_PATTERN_GEN_ABORT_EN is defined.
module tb_seq_pattern_gen;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       out_ready;
`ifdef SEQ_PATTERN_GEN_ABORT_EN
    logic       abort;
`endif
    logic       out_bit;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks;
    int failures;
    int det;
    logic [3:0] det_sh;

    seq_pattern_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .out_ready  (out_ready),
`ifdef SEQ_PATTERN_GEN_ABORT_EN
        .abort      (abort),
`endif
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect the given bit string, one transfer per cycle (out_ready=1).
    task automatic stream(input string tag, input string s);
        logic eb;
        for (int i = 0; i < s.len(); i++) begin
            eb = (s[i] == "1");
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bit"}, 32'(out_bit), 32'(eb));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            det_sh = {det_sh[2:0], out_bit};
            if (det_sh == 4'b1011) det++;
            step();
        end
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_dvalid"}, 32'(out_valid), 32'd0);
        check({tag, "_dbusy"}, 32'(busy), 32'd1);
        step();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic go(input logic [7:0] r, input logic [3:0] g);
        repeat_cnt = r;
        gap_len    = g;
        start      = 1'b1;
        det        = 0;
        det_sh     = 4'b0;
        step();
        start      = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        det        = 0;
        det_sh     = 4'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        repeat_cnt = 8'd0;
        gap_len    = 4'd0;
        out_ready  = 1'b1;
`ifdef SEQ_PATTERN_GEN_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bit", 32'(out_bit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Single pattern.
        go(8'd1, 4'd0);
        stream("basic", "1011");
        expect_done("basic");
        check("basic_det", 32'(det), 32'd1);

        // Three back-to-back repetitions.
        go(8'd3, 4'd0);
        stream("b2b", "101110111011");
        expect_done("b2b");
        check("b2b_det", 32'(det), 32'd3);

        // Two repetitions with a three-bit gap.
        go(8'd2, 4'd3);
        stream("gap", "10110001011");
        expect_done("gap");
        check("gap_det", 32'(det), 32'd2);

        // Back-pressure while the second bit is presented.
        go(8'd1, 4'd0);
        stream("bp_a", "1");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_stall_valid", 32'(out_valid), 32'd1);
            check("bp_stall_bit", 32'(out_bit), 32'd0);
            step();
        end
        out_ready = 1'b1;
        stream("bp_b", "011");
        expect_done("bp");
        check("bp_det", 32'(det), 32'd1);

        // Zero repetitions: immediate done.
        go(8'd0, 4'd2);
        check("zero_valid", 32'(out_valid), 32'd0);
        expect_done("zero");

        // Start while busy is ignored.
        go(8'd2, 4'd1);
        stream("sb_a", "10");
        start      = 1'b1;
        repeat_cnt = 8'd5;
        gap_len    = 4'd0;
        stream("sb_b", "11010");
        start      = 1'b0;
        stream("sb_c", "11");
        expect_done("sb");
        check("sb_det", 32'(det), 32'd2);

        // Asynchronous reset mid-burst.
        go(8'd3, 4'd0);
        stream("rm", "10");
        reset_n = 1'b0;
        #1;
        check("rm_valid", 32'(out_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_bit", 32'(out_bit), 32'd0);
        check("rm_done", 32'(done), 32'd0);
        #2;
        reset_n = 1'b1;
        step();
        check("rm_post_done", 32'(done), 32'd0);
        check("rm_post_busy", 32'(busy), 32'd0);
        step();
        check("rm_post_done2", 32'(done), 32'd0);

`ifdef SEQ_PATTERN_GEN_ABORT_EN
        // Abort during the gap.
        go(8'd2, 4'd3);
        stream("ab", "1011");
        check("ab_gap_valid", 32'(out_valid), 32'd1);
        check("ab_gap_bit", 32'(out_bit), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        step();
        check("ab_done2", 32'(done), 32'd0);
        go(8'd1, 4'd0);
        stream("ab_re", "1011");
        expect_done("ab_re");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Transmit-side counterpart of the overlapping 1011 sequence detector.
- Serializes a fixed bit pattern (default 1011, MSB first) onto a 1-bit stream.
- Repeats the pattern a programmable number of times, with optional zero-filler gaps between repetitions.
- Uses a valid/ready handshake on the output, so it can drive a detector bench directly or go through back-pressured links.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- PAT, 4'b1011, pattern; bit PAT_W-1 is sent first.
- CNT_W, 8, width of repeat count.
- GAP_W, 4, width of gap length.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a burst; accepted only when busy=0.
- repeat_cnt  input  CNT_W  pattern repetitions; sampled on start acceptance.
- gap_len  input  GAP_W  zero bits between repetitions; sampled on start acceptance.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_bit  output  1  serial data.
- out_valid  output  1  out_bit is meaningful.
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (reset_n=0, async) sets state=IDLE, out_bit=0, out_valid=0, busy=0, done=0, and clears all counters and the shift register.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 latches repeat_cnt into rep_left, gap_len into gap_reg, and PAT into the shift register.
  - Next state is SEND if repeat_cnt!=0, else DONE.
  - start while busy=1 is ignored (no queuing).
- SEND:
  - out_valid=1; out_bit = shift-register MSB.
  - A transfer occurs when out_valid && out_ready. Only a transfer shifts left and decrements bit_idx (PAT_W-1 down to 0).
  - If out_ready=0, out_bit and state hold.
  - On transfer of bit_idx=0, rep_left decrements, then:
    - if rep_left was 1 -> DONE;
    - else if gap_reg==0 -> reload PAT, stay in SEND (back-to-back, no bubble);
    - else -> GAP with gap_idx=gap_reg.
- GAP:
  - out_valid=1, out_bit=0.
  - Each transfer decrements gap_idx.
  - On the transfer of the last gap bit: reload PAT, go to SEND.
- DONE:
  - out_valid=0; done=1 for exactly one cycle; next state IDLE.
  - busy stays 1 in DONE.
- Latency:
  - First bit valid the cycle after start is accepted.
  - With out_ready held at 1, a burst spans repeat_cnt*PAT_W + (repeat_cnt-1)*gap_len transfer cycles, plus one DONE cycle.
- out_valid is never deasserted mid-burst; out_bit never changes while out_valid=1 and out_ready=0.
- Reset asserted mid-burst aborts immediately: no done pulse, outputs return to reset values.
- Max repeat_cnt is 2^CNT_W-1; counters never wrap.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SEND or GAP forces IDLE on the next edge: out_valid=0 that cycle onward, no done pulse.
  - abort has priority over a transfer in the same cycle; that bit counts as not sent.
  - abort in IDLE or DONE is ignored.
- Undefined: port absent; burst always runs to completion.

Decomposition:
- Shared package seq_pkg holds:
  - state enum (IDLE, SEND, GAP, DONE);
  - localparam DEF_PAT = 4'b1011;
  - DEF_PAT_W = 4.
- The detector bench uses the same constants.
- One natural sub-module: seq_piso (parallel-load, shift-on-enable register, PAT_W wide, MSB out).
- The FSM and counters stay in the top level.

Test Plan:
- Basic burst: repeat_cnt=1, gap_len=0, out_ready=1 -> bits 1,0,1,1 on cycles 1-4 after start; done pulse on cycle 5; feeding the 1011 detector yields 1 detection.
- Back-to-back with overlap: repeat_cnt=3, gap_len=0 -> stream 101110111011 with no bubble; detector reports 3 detections; busy high for 13 cycles.
- Gaps: repeat_cnt=2, gap_len=3 -> stream 1011 000 1011 (11 transfers); done after the 11th.
- Back-pressure: repeat_cnt=1; hold out_ready=0 for 5 cycles after bit 2 -> out_bit stays 0 and out_valid stays 1 throughout the stall; the stream is still 1011 with no bit lost or duplicated.
- Edge cases:
  - repeat_cnt=0 -> no valid bits, done pulse the cycle after start.
  - start while busy -> ignored.
  - reset_n low mid-SEND -> out_valid=0 immediately (async), no done pulse.
- With SEQ_PATTERN_GEN_ABORT_EN: abort during GAP -> IDLE next cycle, no done pulse; a following start with repeat_cnt=1 sends a clean 1011.
